alu_pipe_seq: RTL

- Parametrised, registered successor to the team's 8-bit combinational ALU: same 4-bit opcode space, generic WIDTH.
- Adds valid/ready handshakes on input and output, a multi-cycle shift-add multiplier and a persistent accumulator.
- Sits between the datapath controller and the writeback stage; only one operation is in flight at a time.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_mul_seq.sv | 34 +++
 rtl/alu_pipe_seq.sv | 56 +++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM encoding and the single-cycle ALU function shared by the ALU slice.
package alu_pkg;
  localparam int MAXW = 64;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3;
  localparam logic [3:0] OP_NOT = 4'h4, OP_XOR = 4'h5, OP_NOR = 4'h6, OP_SLL = 4'h7;
  localparam logic [3:0] OP_SRL = 4'h8, OP_SRA = 4'h9, OP_ROL = 4'hA, OP_ROR = 4'hB;
  localparam logic [3:0] OP_EQ  = 4'hC, OP_SLT = 4'hD, OP_MUL = 4'hE, OP_ACC = 4'hF;
  localparam logic [0:0] ST_IDLE = 1'b0, ST_MULT = 1'b1;
  // Operands arrive zero-extended to MAXW; w is the live width. Returns {carry, result}.
  function automatic logic [MAXW:0] alu_calc(input logic [3:0] op, input logic [MAXW-1:0] a,
                                             input logic [MAXW-1:0] b, input int sh,
                                             input logic big, input int w);
    logic [MAXW-1:0] m, sa, sb;
    logic [MAXW:0] s;
    m = (w >= MAXW) ? '1 : ((MAXW'(1) << w) - MAXW'(1));
    sa = |(a & ~(m >> 1)) ? (a | ~m) : a;
    sb = |(b & ~(m >> 1)) ? (b | ~m) : b;
    s = '0;
    case (op)
      OP_ADD: s = {1'b0, a} + {1'b0, b};
      OP_SUB: s = {1'b0, a} + {1'b0, ~b & m} + (MAXW+1)'(1);
      OP_AND: s[MAXW-1:0] = a & b;
      OP_OR:  s[MAXW-1:0] = a | b;
      OP_NOT: s[MAXW-1:0] = ~a;
      OP_XOR: s[MAXW-1:0] = a ^ b;
      OP_NOR: s[MAXW-1:0] = ~(a | b);
      OP_SLL: s[MAXW-1:0] = big ? '0 : a << sh;
      OP_SRL: s[MAXW-1:0] = big ? '0 : a >> sh;
      OP_SRA: s[MAXW-1:0] = $signed(sa) >>> (big ? w - 1 : sh);
      OP_ROL: s[MAXW-1:0] = (a << 1) | (a >> (w - 1));
      OP_ROR: s[MAXW-1:0] = (a >> 1) | (a << (w - 1));
      OP_EQ:  s[0] = a == b;
      OP_SLT: s[0] = $signed(sa) < $signed(sb);
      default: s = '0;
    endcase
    return {(op == OP_ADD || op == OP_SUB) && |(s >> w), s[MAXW-1:0] & m};
  endfunction
endpackage

// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier, one multiplier bit per cycle; done while count is zero.
module alu_mul_seq #(parameter int WIDTH = 8) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0] count;
  assign done = count == '0;
  // mcand shifts left each step, so it always equals multiplicand << (WIDTH-count)
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mcand <= '0;
      mplier <= '0;
      count <= '0;
      product <= '0;
    end else if (start) begin
      mcand <= (2*WIDTH)'(a);
      mplier <= b;
      count <= CW'(WIDTH);
      product <= '0;
    end else if (!done) begin
      product <= mplier[0] ? product + mcand : product;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      count <= count - CW'(1);
    end
endmodule

// File: rtl/alu_pipe_seq.sv
// alu_pipe_seq: registered ALU with valid/ready handshakes, sequential multiplier and accumulator.
module alu_pipe_seq import alu_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero
);
  logic [0:0] state;
  logic [WIDTH-1:0] acc, wr_out;
  logic [MAXW:0] r;
  logic [2*WIDTH-1:0] prod;
  logic take, mul_go, mul_done, mul_fin, wr, wr_c, unused_hi;
  assign in_ready = state == ST_IDLE && (!out_valid || out_ready);
  assign take = in_valid && in_ready;
  assign mul_go = take && ctrl == OP_MUL;
  // the multiplier parks at count 0 until the result register can take its product
  assign mul_fin = state == ST_MULT && mul_done && (!out_valid || out_ready);
  assign wr = (take && ctrl != OP_MUL) || mul_fin;
  assign r = alu_calc(ctrl == OP_ACC ? OP_ADD : ctrl, MAXW'(x), MAXW'(ctrl == OP_ACC ? acc : y),
                      int'(y[SHW-1:0]), y >= WIDTH'(WIDTH), WIDTH);
  assign wr_out = mul_fin ? prod[WIDTH-1:0] : r[WIDTH-1:0];
  assign wr_c = mul_fin ? |prod[2*WIDTH-1:WIDTH] : r[MAXW];
  assign unused_hi = ^(r[MAXW-1:0] >> WIDTH);
  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk(clk), .reset(reset), .start(mul_go), .a(x), .b(y), .done(mul_done), .product(prod)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      out <= '0;
      carry <= 1'b0;
      zero <= 1'b1;
      out_valid <= 1'b0;
      acc <= '0;
    end else begin
      if (wr) begin
        out <= wr_out;
        carry <= wr_c;
        zero <= wr_out == '0;
      end
      out_valid <= wr || (out_valid && !out_ready);
      if (take && ctrl == OP_ACC) acc <= r[WIDTH-1:0];
      state <= mul_go ? ST_MULT : mul_fin ? ST_IDLE : state;
    end
endmodule
